// File: rtl/hack_fetch.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack handshake and holds each one for the control unit.
// Optional macro HACK_FETCH_COUNT_EN enables the 16-bit fetched-instruction counter.
module hack_fetch #(
    parameter int INSTR_W = 19,
    parameter int ADDR_W  = 15
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               stall,
    input  logic               jmp_en,
    input  logic [ADDR_W-1:0]  jmp_addr,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    output logic [15:0]        fetch_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                accept;
    logic [ADDR_W-1:0]   pc;

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                if (!jmp_en && imem_ack) begin
                    state_next = HOLD;
                    accept     = 1'b1;
                end
            end
            HOLD: begin
                if (jmp_en || !stall) state_next = REQ;
            end
            default: state_next = IDLE;
        endcase
        // A redirect from any live state restarts fetching at the new target.
        if (jmp_en) state_next = REQ;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else begin
            state <= state_next;
            if (jmp_en) begin
                pc          <= jmp_addr;
                instr_valid <= 1'b0;
            end else if (accept) begin
                instr       <= imem_data;
                instr_pc    <= pc;
                pc          <= pc + ADDR_W'(1);
                instr_valid <= 1'b1;
            end else if (state == HOLD && !stall) begin
                instr_valid <= 1'b0;
            end
        end
    end

`ifdef HACK_FETCH_COUNT_EN
    logic [15:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (accept) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign fetch_count = count_q;
`else
    assign fetch_count = 16'd0;
`endif

    assign imem_req  = (state == REQ);
    assign imem_addr = pc;

endmodule

// File: tb/tb_hack_fetch.sv
// Self-checking bench for hack_fetch: directed test-plan steps followed by randomized cycles,
// all compared against a transaction-level reference model.
module tb_hack_fetch;

    localparam int INSTR_W = 19;
    localparam int ADDR_W  = 15;

    logic               clk;
    logic               reset;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_data;
    logic               stall;
    logic               jmp_en;
    logic [ADDR_W-1:0]  jmp_addr;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic [15:0]        fetch_count;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: "fresh" means the cycle right after reset, "valid" means an
    // instruction is being held; otherwise the stage is waiting on memory.
    logic               m_fresh;
    logic               m_valid;
    logic [ADDR_W-1:0]  m_pc;
    logic [INSTR_W-1:0] m_instr;
    logic [ADDR_W-1:0]  m_ipc;
    logic [15:0]        m_cnt;

    hack_fetch #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .stall       (stall),
        .jmp_en      (jmp_en),
        .jmp_addr    (jmp_addr),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .fetch_count (fetch_count)
    );

    function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {4'b1000, a};
    endfunction

    // Instruction memory contents as seen on the data bus for the presented address.
    assign imem_data = mem_word(imem_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_count();
`ifdef HACK_FETCH_COUNT_EN
        return m_cnt;
`else
        return 16'd0;
`endif
    endfunction

    task automatic model_edge(input logic r, input logic a, input logic s,
                              input logic j, input logic [ADDR_W-1:0] ja);
        if (r) begin
            m_fresh = 1'b1; m_valid = 1'b0; m_pc = '0;
            m_instr = '0;   m_ipc = '0;     m_cnt = '0;
        end else if (j) begin
            m_fresh = 1'b0; m_valid = 1'b0; m_pc = ja;
        end else if (m_fresh) begin
            m_fresh = 1'b0;
        end else if (!m_valid) begin
            if (a) begin
                m_instr = mem_word(m_pc);
                m_ipc   = m_pc;
                m_pc    = m_pc + 1;
                m_valid = 1'b1;
                m_cnt   = m_cnt + 1;
            end
        end else if (!s) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("imem_req",    32'(imem_req),    32'(!m_fresh && !m_valid));
        check("imem_addr",   32'(imem_addr),   32'(m_pc));
        check("instr_valid", 32'(instr_valid), 32'(m_valid));
        check("instr",       32'(instr),       32'(m_instr));
        check("instr_pc",    32'(instr_pc),    32'(m_ipc));
        check("fetch_count", 32'(fetch_count), 32'(exp_count()));
    endtask

    task automatic step(input logic r, input logic a, input logic s,
                        input logic j, input logic [ADDR_W-1:0] ja);
        reset = r; imem_ack = a; stall = s; jmp_en = j; jmp_addr = ja;
        @(posedge clk);
        model_edge(r, a, s, j, ja);
        #1;
        compare_all();
        @(negedge clk);
    endtask

    logic [15:0] saved_cnt;

    initial begin
        reset = 1'b1; imem_ack = 1'b0; stall = 1'b0; jmp_en = 1'b0; jmp_addr = '0;
        m_fresh = 1'b1; m_valid = 1'b0; m_pc = '0; m_instr = '0; m_ipc = '0; m_cnt = '0;

        // Sequential fetch with a zero-wait memory.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_req",   32'(imem_req),    32'd0);
        step(0, 1, 0, 0, 0);
        check("seq_req_edge1", 32'(imem_req), 32'd1);
        step(0, 1, 0, 0, 0);
        check("seq_first_instr", 32'(instr), 32'h40000);
        check("seq_first_valid", 32'(instr_valid), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            step(0, 1, 0, 0, 0);
            step(0, 1, 0, 0, 0);
            check("seq_pc", 32'(instr_pc), 32'(k));
        end

        // Wait states on address 0.
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0, 0);
            check("wait_req",   32'(imem_req),    32'd1);
            check("wait_addr",  32'(imem_addr),   32'd0);
            check("wait_valid", 32'(instr_valid), 32'd0);
        end
        step(0, 1, 0, 0, 0);
        check("wait_pc_after", 32'(imem_addr), 32'd1);

        // Walk up to instr_pc=5, then stall for four cycles.
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, 0, 0);
            step(0, 1, 0, 0, 0);
        end
        check("stall_setup_pc", 32'(instr_pc), 32'd5);
        for (int k = 0; k < 4; k++) begin
            step(0, 1'($urandom_range(0, 1)), 1, 0, 0);
            check("stall_pc",    32'(instr_pc),    32'd5);
            check("stall_instr", 32'(instr),       32'(mem_word(15'd5)));
            check("stall_req",   32'(imem_req),    32'd0);
        end
        step(0, 0, 0, 0, 0);
        check("stall_next_addr", 32'(imem_addr), 32'd6);

        // Jump flushes a stalled instruction.
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 15'h0100);
        check("jmp_flush_valid", 32'(instr_valid), 32'd0);
        check("jmp_flush_addr",  32'(imem_addr),   32'h0100);
        step(0, 1, 0, 0, 0);
        check("jmp_flush_ipc", 32'(instr_pc), 32'h0100);

        // Jump simultaneous with ack: data discarded.
        step(0, 0, 0, 0, 0);
        saved_cnt = exp_count();
        step(0, 1, 0, 1, 15'h0020);
        check("jmp_ack_valid", 32'(instr_valid), 32'd0);
        check("jmp_ack_addr",  32'(imem_addr),   32'h0020);
        check("jmp_ack_count", 32'(fetch_count), 32'(saved_cnt));

        // PC wrap at the top of the address space, then reset during REQ.
        step(0, 0, 0, 1, 15'h7FFF);
        step(0, 1, 0, 0, 0);
        check("wrap_ipc", 32'(instr_pc),  32'h7FFF);
        check("wrap_pc",  32'(imem_addr), 32'd0);
        step(0, 0, 0, 0, 0);
        check("wrap_req", 32'(imem_req), 32'd1);
        step(1, 1, 0, 1, 15'h1234);
        check("midrst_req",   32'(imem_req),    32'd0);
        check("midrst_addr",  32'(imem_addr),   32'd0);
        check("midrst_valid", 32'(instr_valid), 32'd0);
        check("midrst_instr", 32'(instr),       32'd0);
        check("midrst_count", 32'(fetch_count), 32'd0);

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            logic             r, a, s, j;
            logic [ADDR_W-1:0] ja;
            r  = ($urandom_range(0, 63) == 0);
            a  = ($urandom_range(0, 1) == 1);
            s  = ($urandom_range(0, 4) < 2);
            j  = ($urandom_range(0, 9) == 0);
            ja = ($urandom_range(0, 3) == 0) ? ADDR_W'(15'h7FFE + $urandom_range(0, 1))
                                             : ADDR_W'($urandom);
            step(r, a, s, j, ja);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
